lift_motion_controller: RTL and testbench

- Closed-loop lift controller that drives `direction`/`motion` into the lift movement model and reads back one-hot `floor_sense`.
- Latches floor requests and serves them in SCAN order: keep the current direction while requests remain ahead.
- Stops only at floor contact, holds the door open for a fixed time, and flags sensor/travel faults.
- Sits between the request inputs (call buttons) and the lift mechanics; it is the initiator side of the movement model's motion/sense interface.

---
 rtl/lift_pkg.sv | 35 +++
 rtl/lift_door_timer.sv | 32 +++
 rtl/lift_motion_controller.sv | 141 ++++++++++++++
 tb/tb_lift_motion_controller.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared types and helpers for the lift motion controller.
package lift_pkg;

  // Widest floor vector the helpers accept; narrower vectors are zero-extended.
  localparam int MAX_FLOORS = 32;

  typedef logic [MAX_FLOORS-1:0] floor_vec_t;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_IDLE,
    ST_MOVE,
    ST_DOOR,
    ST_FAULT
  } lift_state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Exactly one bit set.
  function automatic logic is_onehot(floor_vec_t v);
    return (v != '0) && ((v & (v - floor_vec_t'(1))) == '0);
  endfunction

  // Any pending bit strictly above the one-hot floor.
  function automatic logic any_above(floor_vec_t pend, floor_vec_t floor);
    return |(pend & ~((floor << 1) - floor_vec_t'(1)));
  endfunction

  // Any pending bit strictly below the one-hot floor.
  function automatic logic any_below(floor_vec_t pend, floor_vec_t floor);
    return |(pend & (floor - floor_vec_t'(1)));
  endfunction

endpackage

// File: rtl/lift_door_timer.sv
// Door dwell timer: a start pulse opens a window of DOOR_OPEN_REQ cycles,
// done is high in the last cycle of that window.
module lift_door_timer #(
  parameter int DOOR_OPEN_REQ = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);
  localparam int CW = $clog2(DOOR_OPEN_REQ + 1);

  logic [CW-1:0] cnt;
  logic          running;

  // Count down from DOOR_OPEN_REQ-1 to zero after each start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= CW'(DOOR_OPEN_REQ - 1);
    end else if (running) begin
      if (cnt == '0) running <= 1'b0;
      else           cnt     <= cnt - 1'b1;
    end
  end

  assign done = running && (cnt == '0);

endmodule

// File: rtl/lift_motion_controller.sv
// SCAN-order lift controller: latches requests, drives motion/direction,
// stops on floor contact, times the door and flags sensor/travel faults.
module lift_motion_controller
  import lift_pkg::*;
#(
  parameter int N_FLOORS      = 12,
  parameter int DOOR_OPEN_REQ = 100,
  parameter int T_WATCHDOG    = 400
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] req_floor,
  input  logic [N_FLOORS-1:0] floor_sense,
  output logic                motion,
  output logic                direction,
  output logic                door_open,
  output logic [N_FLOORS-1:0] current_floor,
  output logic [N_FLOORS-1:0] pending,
  output logic                fault
);
  localparam int WW = $clog2(T_WATCHDOG + 1);

  lift_state_e         state;
  logic [WW-1:0]       wdog;
  logic [N_FLOORS-1:0] pend_next;
  logic                sense_legal, sense_bad, arrival;
  logic                arr_door, arr_end, arr_ahead;
  logic                here_req, ahead_idle, behind_idle;
  logic                door_start, door_done;
  floor_vec_t          sense_w, cur_w, pend_w;

  // Sensor classification and SCAN direction decisions.
  always_comb begin
    sense_w     = floor_vec_t'(floor_sense);
    cur_w       = floor_vec_t'(current_floor);
    pend_w      = floor_vec_t'(pending);
    sense_legal = is_onehot(sense_w);
    sense_bad   = (floor_sense != '0) && !sense_legal;
    arrival     = sense_legal && (floor_sense != current_floor);
    arr_door    = |(pending & floor_sense);
    arr_end     = direction ? floor_sense[N_FLOORS-1] : floor_sense[0];
    arr_ahead   = direction ? any_above(pend_w, sense_w) : any_below(pend_w, sense_w);
    here_req    = |(pending & current_floor);
    ahead_idle  = direction ? any_above(pend_w, cur_w) : any_below(pend_w, cur_w);
    behind_idle = direction ? any_below(pend_w, cur_w) : any_above(pend_w, cur_w);
    // A request for the floor whose door is already open is dropped.
    pend_next   = pending | ((state == ST_DOOR) ? (req_floor & ~current_floor) : req_floor);
    door_start  = !sense_bad &&
                  (((state == ST_IDLE) && here_req) ||
                   ((state == ST_MOVE) && arrival && arr_door));
  end

  lift_door_timer #(.DOOR_OPEN_REQ(DOOR_OPEN_REQ)) u_door_timer (
    .clk   (clk),
    .rst   (rst),
    .start (door_start),
    .done  (door_done)
  );

  // Main controller FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_SYNC;
      motion        <= 1'b0;
      direction     <= DIR_UP;
      door_open     <= 1'b0;
      current_floor <= N_FLOORS'(1);
      pending       <= '0;
      fault         <= 1'b0;
      wdog          <= '0;
    end else begin
      if (sense_legal) current_floor <= floor_sense;
      pending <= pend_next;
      if ((state != ST_FAULT) && sense_bad) begin
        state     <= ST_FAULT;
        motion    <= 1'b0;
        door_open <= 1'b0;
        fault     <= 1'b1;
      end else begin
        case (state)
          ST_SYNC: begin
            // Reset between floors: creep down to the nearest contact.
            if (floor_sense != '0) begin
              motion <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              motion    <= 1'b1;
              direction <= DIR_DN;
            end
          end
          ST_IDLE: begin
            if (here_req) begin
              state     <= ST_DOOR;
              door_open <= 1'b1;
              pending   <= pend_next & ~current_floor;
            end else if (ahead_idle) begin
              motion <= 1'b1;
              state  <= ST_MOVE;
              wdog   <= '0;
            end else if (behind_idle) begin
              // Reverse while stationary; motion starts next cycle.
              direction <= ~direction;
            end
          end
          ST_MOVE: begin
            if (arrival) begin
              wdog <= '0;
              if (arr_door) begin
                motion    <= 1'b0;
                door_open <= 1'b1;
                state     <= ST_DOOR;
                pending   <= pend_next & ~floor_sense;
              end else if (arr_end || !arr_ahead) begin
                motion <= 1'b0;
                state  <= ST_IDLE;
              end
            end else if (wdog >= WW'(T_WATCHDOG - 1)) begin
              state  <= ST_FAULT;
              motion <= 1'b0;
              fault  <= 1'b1;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
          ST_DOOR: begin
            if (door_done) begin
              door_open <= 1'b0;
              state     <= ST_IDLE;
            end
          end
          default: begin
            motion    <= 1'b0;
            door_open <= 1'b0;
            fault     <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lift_motion_controller.sv
// Directed bench: a simple shaft model closes the loop, a scoreboard checks
// every door stop (floor and dwell length) against a queue of expected stops.
module tb_lift_motion_controller;
  localparam int NF    = 12;
  localparam int T_FLR = 200;
  localparam int HALF  = 25;

  logic          clk, rst;
  logic [NF-1:0] req_floor, floor_sense, model_sense, current_floor, pending, force_val;
  logic          motion, direction, door_open, fault, force_en;
  int            pos = 0;

  int checks = 0, failures = 0, overlap = 0;
  logic [NF-1:0] exp_q[$];

  lift_motion_controller #(.N_FLOORS(NF), .DOOR_OPEN_REQ(100), .T_WATCHDOG(400)) dut (
    .clk(clk), .rst(rst), .req_floor(req_floor), .floor_sense(floor_sense),
    .motion(motion), .direction(direction), .door_open(door_open),
    .current_floor(current_floor), .pending(pending), .fault(fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shaft model: one position unit per moving cycle, contact window of 2*HALF around each floor.
  always @(posedge clk) if (motion) pos <= direction ? pos + 1 : pos - 1;

  always_comb begin
    model_sense = '0;
    for (int k = 0; k < NF; k++)
      if (pos > k * T_FLR - HALF && pos < k * T_FLR + HALF) model_sense[k] = 1'b1;
    floor_sense = force_en ? force_val : model_sense;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: pop an expected floor on every door opening, check the dwell length.
  initial begin
    int   cnt;
    logic prev;
    logic [NF-1:0] e;
    cnt  = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (door_open && motion) overlap++;
      if (door_open && !prev) begin
        if (exp_q.size() == 0) begin
          chk("door_unexpected", 32'(current_floor), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("door_floor", 32'(current_floor), 32'(e));
        end
        chk("door_motion", 32'(motion), 32'(0));
        cnt = 1;
      end else if (door_open) begin
        cnt++;
      end else if (prev) begin
        chk("door_len", 32'(cnt), 32'(100));
      end
      prev = door_open;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req(input logic [NF-1:0] v);
    req_floor = v;
    @(negedge clk);
    req_floor = '0;
  endtask

  task automatic wait_sense(input logic [NF-1:0] v, input int bound, input string nm);
    int i = 0;
    while (floor_sense !== v && i < bound) begin @(negedge clk); i++; end
    chk(nm, 32'(floor_sense), 32'(v));
  endtask

  task automatic wait_door(input logic lvl, input int bound, input string nm);
    int i = 0;
    while (door_open !== lvl && i < bound) begin @(negedge clk); i++; end
    chk(nm, 32'(door_open), 32'(lvl));
  endtask

  initial begin
    int i;
    rst = 1'b1; req_floor = '0; force_en = 1'b0; force_val = '0;
    step(2);
    chk("rst_motion", 32'(motion), 32'(0));
    chk("rst_dir", 32'(direction), 32'(1));
    chk("rst_door", 32'(door_open), 32'(0));
    chk("rst_cur", 32'(current_floor), 32'(1));
    chk("rst_pend", 32'(pending), 32'(0));
    chk("rst_fault", 32'(fault), 32'(0));
    rst = 1'b0;
    step(3);

    // Ground to floor 3.
    exp_q.push_back(12'h008);
    pulse_req(12'h008);
    step(1);
    chk("t1_motion_2cyc", 32'(motion), 32'(1));
    chk("t1_dir", 32'(direction), 32'(1));
    wait_sense(12'h008, 1000, "t1_arrive");
    step(1);
    chk("t1_stop_1cyc", 32'(motion), 32'(0));
    wait_door(1'b0, 200, "t1_door_close");
    chk("t1_pend", 32'(pending), 32'(0));
    chk("t1_cur", 32'(current_floor), 32'(12'h008));

    // Two simultaneous requests: keep going up to 10, then reverse to ground.
    exp_q.push_back(12'h400);
    exp_q.push_back(12'h001);
    pulse_req(12'h401);
    chk("t2_both_latched", 32'(pending), 32'(12'h401));
    wait_door(1'b1, 2000, "t2_door10_open");
    wait_door(1'b0, 200, "t2_door10_close");
    i = 0;
    while (direction !== 1'b0 && i < 10) begin @(negedge clk); i++; end
    chk("t2_dir_flip", 32'(direction), 32'(0));
    chk("t2_flip_before_motion", 32'(motion), 32'(0));
    step(1);
    chk("t2_move_after_flip", 32'(motion), 32'(1));
    wait_door(1'b1, 3000, "t2_door0_open");
    wait_door(1'b0, 200, "t2_door0_close");
    chk("t2_cur", 32'(current_floor), 32'(12'h001));
    chk("t2_pend", 32'(pending), 32'(0));

    // Floor 5 requested while passing floor 4 on the way to floor 7.
    exp_q.push_back(12'h020);
    exp_q.push_back(12'h080);
    pulse_req(12'h080);
    wait_sense(12'h010, 1500, "t3_pass4");
    pulse_req(12'h020);
    wait_door(1'b1, 800, "t3_door5_open");
    wait_door(1'b0, 200, "t3_door5_close");
    wait_door(1'b1, 800, "t3_door7_open");
    // Re-request the open floor: must be dropped, dwell unchanged.
    step(10);
    pulse_req(12'h080);
    chk("t6_req_dropped", 32'(pending), 32'(0));
    wait_door(1'b0, 200, "t6_door_close");
    step(5);
    chk("t6_no_reopen", 32'(door_open), 32'(0));
    chk("t6_idle", 32'(motion), 32'(0));

    // Reset between floors 3 and 2 while heading down.
    pulse_req(12'h001);
    wait_sense(12'h008, 1500, "t4_pass3");
    wait_sense(12'h000, 100, "t4_leave3");
    step(50);
    rst = 1'b1;
    step(2);
    chk("t4_rst_cur", 32'(current_floor), 32'(1));
    rst = 1'b0;
    step(2);
    chk("t4_sync_motion", 32'(motion), 32'(1));
    chk("t4_sync_dir", 32'(direction), 32'(0));
    wait_sense(12'h004, 400, "t4_reach2");
    step(1);
    chk("t4_sync_stop", 32'(motion), 32'(0));
    chk("t4_sync_cur", 32'(current_floor), 32'(12'h004));
    chk("t4_sync_pend", 32'(pending), 32'(0));

    // Illegal sensor code.
    step(3);
    force_val = 12'h006; force_en = 1'b1;
    step(1);
    chk("t5_fault", 32'(fault), 32'(1));
    chk("t5_fault_motion", 32'(motion), 32'(0));
    force_en = 1'b0;
    pulse_req(12'h020);
    step(5);
    chk("t5_fault_sticky", 32'(fault), 32'(1));
    chk("t5_fault_still", 32'(motion), 32'(0));
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(3);
    chk("t5_fault_cleared", 32'(fault), 32'(0));

    // Watchdog: no contact while moving.
    pulse_req(12'h020);
    wait_sense(12'h000, 100, "t5_leave2");
    force_val = '0; force_en = 1'b1;
    step(300);
    chk("t5_wdog_early", 32'(fault), 32'(0));
    i = 0;
    while (fault !== 1'b1 && i < 200) begin @(negedge clk); i++; end
    chk("t5_wdog_fault", 32'(fault), 32'(1));
    chk("t5_wdog_motion", 32'(motion), 32'(0));

    chk("sb_drained", 32'(exp_q.size()), 32'(0));
    chk("door_motion_overlap", 32'(overlap), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
